// File: rtl/teclado_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : teclado_pkg
//  Description : Shared constants, scan FSM state type and key helper
//                functions for the 3x4 keypad scan controller.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Contents
//    NUM_COLS, NUM_ROWS, KEY_W   keypad geometry and key-code width
//    scan_state_t                SCAN / DEBOUNCE / PRESSED / RELEASE
//    lowest_low_row()            index of the lowest active-low row
//    encode_key()                col*4 + row
//    col_drive()                 one-cold column drive pattern
// ============================================================================
package teclado_pkg;

   localparam int NUM_COLS = 3;
   localparam int NUM_ROWS = 4;
   localparam int KEY_W    = 4;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   // Rows are active-low; the lowest-index low bit wins when several are low.
   function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows);
      logic [1:0] r;
      r = 2'd0;
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
         if (!rows[i]) begin
            r = 2'(i);
         end
      end
      return r;
   endfunction

   // col*4 + row is exactly the concatenation {col, row} for a 4-row pad.
   function automatic logic [KEY_W-1:0] encode_key(input logic [1:0] col,
                                                   input logic [1:0] row);
      return {col, row};
   endfunction

   // Driven column is the only low bit.
   function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] col);
      return ~(3'b001 << col);
   endfunction

endpackage : teclado_pkg
`default_nettype wire

// File: rtl/teclado_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : teclado_fifo
//  Description : Synchronous show-ahead FIFO for key codes. The head entry is
//                always visible on o_head_data. A push into a full FIFO is
//                dropped and reported by a one-cycle overflow pulse, unless a
//                pop happens in the same cycle, in which case both proceed.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   system clock
//    reset            in   asynchronous active-high reset
//    i_push           in   write request
//    i_push_data      in   WIDTH  data to write
//    i_pop            in   read request (ignored while empty)
//    o_head_data      out  WIDTH  head entry
//    o_full           out  FIFO holds DEPTH entries
//    o_empty          out  FIFO holds no entries
//    o_count          out  $clog2(DEPTH)+1  occupancy
//    o_overflow_pulse out  a push was dropped this cycle
// ============================================================================
module teclado_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overflow_pulse
);

   localparam int                 c_aw    = $clog2(DEPTH);
   localparam logic [c_aw:0]      c_depth = (c_aw + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;

   logic w_pop_fire;
   logic w_push_fire;

   assign o_full  = (r_count == c_depth);
   assign o_empty = (r_count == '0);

   // When full, a simultaneous pop frees the slot the push writes into
   // (wr_ptr == rd_ptr), so the pair is accepted with no drop.
   assign w_pop_fire       = i_pop & ~o_empty;
   assign w_push_fire      = i_push & (~o_full | w_pop_fire);
   assign o_overflow_pulse = i_push & o_full & ~w_pop_fire;

   assign o_head_data = r_mem[r_rd_ptr];
   assign o_count     = r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push_fire) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop_fire) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_fire, w_pop_fire})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : teclado_fifo
`default_nettype wire

// File: rtl/teclado_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : teclado_scan_ctrl
//  Description : Scan controller for the 3-column x 4-row bicycle-rack keypad.
//                Drives one column low per dwell period, samples the
//                synchronised rows at the end of each dwell, debounces press
//                and release, and queues key codes (col*4+row) in a
//                show-ahead FIFO popped through key_valid/key_pop.
//                Optional auto-repeat while a key is held is enabled by
//                defining TECLADO_AUTOREPEAT_EN.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                  in   system clock
//    reset                in   asynchronous active-high reset
//    entrada1..entrada4   in   row inputs, active-low, asynchronous
//    teclasalida          out  3  column drive, one-cold active-low
//    key_code             out  4  FIFO head code
//    key_valid            out  FIFO non-empty
//    key_pop              in   pop strobe
//    fifo_count           out  $clog2(FIFO_DEPTH)+1  occupancy
//    overflow             out  sticky: a key code was dropped
//    clr_overflow         in   clears overflow (a same-cycle set wins)
// ============================================================================
module teclado_scan_ctrl
   import teclado_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 4,
   parameter int REPEAT_SCANS   = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          entrada1,
   input  logic                          entrada2,
   input  logic                          entrada3,
   input  logic                          entrada4,
   output logic [NUM_COLS-1:0]           teclasalida,
   output logic [KEY_W-1:0]              key_code,
   output logic                          key_valid,
   input  logic                          key_pop,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          clr_overflow
);

   localparam int                    c_dwell_w   = $clog2(SCAN_DIV);
   localparam logic [c_dwell_w-1:0]  c_dwell_end = c_dwell_w'(SCAN_DIV - 1);
   localparam int                    c_deb_w     = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [c_deb_w-1:0]    c_deb_tgt   = c_deb_w'(DEBOUNCE_SCANS);

   // Elaboration-time parameter sanity check.
   if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_SCANS < 1) begin : g_bad_params
      $error("teclado_scan_ctrl: illegal parameter value");
   end

   // ------------------------------------------------------------------
   // Row synchroniser
   // ------------------------------------------------------------------
   logic [NUM_ROWS-1:0] r_row_meta;
   logic [NUM_ROWS-1:0] r_row_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row_meta <= '1;
         r_row_s    <= '1;
      end else begin
         r_row_meta <= {entrada4, entrada3, entrada2, entrada1};
         r_row_s    <= r_row_meta;
      end
   end

   // ------------------------------------------------------------------
   // Scan state
   // ------------------------------------------------------------------
   scan_state_t           r_state;
   logic [1:0]            r_col;
   logic [NUM_COLS-1:0]   r_col_drive;
   logic [c_dwell_w-1:0]  r_dwell;
   logic [1:0]            r_cand_row;
   logic [c_deb_w-1:0]    r_deb_cnt;

   logic                  w_sample;
   logic                  w_any_low;
   logic [1:0]            w_low_row;
   logic                  w_match;
   logic [c_deb_w-1:0]    w_deb_next;
   logic                  w_deb_done;
   logic [1:0]            w_col_next;
   logic                  w_push;
   logic [1:0]            w_push_row;
   logic [KEY_W-1:0]      w_push_code;
   logic                  w_rep_done;

   assign w_sample   = (r_dwell == c_dwell_end);
   assign w_any_low  = (r_row_s != '1);
   assign w_low_row  = lowest_low_row(r_row_s);
   assign w_match    = w_any_low && (w_low_row == r_cand_row);
   assign w_deb_next = r_deb_cnt + 1'b1;
   assign w_deb_done = (w_deb_next == c_deb_tgt);
   assign w_col_next = (r_col == 2'(NUM_COLS - 1)) ? 2'd0 : r_col + 2'd1;

`ifdef TECLADO_AUTOREPEAT_EN
   // ------------------------------------------------------------------
   // Auto-repeat: count held samples in PRESSED, push every REPEAT_SCANS.
   // Held outside PRESSED at zero, which clears it on every entry.
   // ------------------------------------------------------------------
   localparam int                  c_rep_w   = $clog2(REPEAT_SCANS + 1);
   localparam logic [c_rep_w-1:0]  c_rep_tgt = c_rep_w'(REPEAT_SCANS);

   logic [c_rep_w-1:0] r_rep_cnt;
   logic [c_rep_w-1:0] w_rep_next;

   assign w_rep_next = r_rep_cnt + 1'b1;
   assign w_rep_done = (w_rep_next == c_rep_tgt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rep_cnt <= '0;
      end else if (r_state != PRESSED) begin
         r_rep_cnt <= '0;
      end else if (w_sample && w_any_low) begin
         r_rep_cnt <= w_rep_done ? '0 : w_rep_next;
      end
   end
`else
   assign w_rep_done = 1'b0;
`endif

   // Push is combinational so it lands in the FIFO at the end of the
   // sample-point cycle; key_valid follows one edge later.
   always_comb begin
      w_push = 1'b0;
      if (w_sample) begin
         case (r_state)
            SCAN:     w_push = w_any_low && (DEBOUNCE_SCANS == 1);
            DEBOUNCE: w_push = w_match && w_deb_done;
            PRESSED:  w_push = w_any_low && w_rep_done;
            default:  w_push = 1'b0;
         endcase
      end
   end

   // In SCAN the candidate has not been latched yet, so use the live row.
   assign w_push_row  = (r_state == SCAN) ? w_low_row : r_cand_row;
   assign w_push_code = encode_key(r_col, w_push_row);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= SCAN;
         r_col       <= 2'd0;
         r_col_drive <= col_drive(2'd0);
         r_dwell     <= '0;
         r_cand_row  <= 2'd0;
         r_deb_cnt   <= '0;
      end else begin
         r_dwell <= w_sample ? '0 : r_dwell + 1'b1;

         if (w_sample) begin
            case (r_state)
               SCAN: begin
                  if (!w_any_low) begin
                     r_col       <= w_col_next;
                     r_col_drive <= col_drive(w_col_next);
                  end else begin
                     r_cand_row <= w_low_row;
                     r_deb_cnt  <= c_deb_w'(1);
                     r_state    <= (DEBOUNCE_SCANS == 1) ? PRESSED : DEBOUNCE;
                  end
               end

               DEBOUNCE: begin
                  if (w_match) begin
                     r_deb_cnt <= w_deb_next;
                     if (w_deb_done) begin
                        r_state <= PRESSED;
                     end
                  end else begin
                     // Bounce: give up on this column and move on.
                     r_state     <= SCAN;
                     r_col       <= w_col_next;
                     r_col_drive <= col_drive(w_col_next);
                  end
               end

               PRESSED: begin
                  if (!w_any_low) begin
                     r_deb_cnt <= c_deb_w'(1);
                     if (DEBOUNCE_SCANS == 1) begin
                        r_state     <= SCAN;
                        r_col       <= w_col_next;
                        r_col_drive <= col_drive(w_col_next);
                     end else begin
                        r_state <= RELEASE;
                     end
                  end
               end

               RELEASE: begin
                  if (!w_any_low) begin
                     r_deb_cnt <= w_deb_next;
                     if (w_deb_done) begin
                        r_state     <= SCAN;
                        r_col       <= w_col_next;
                        r_col_drive <= col_drive(w_col_next);
                     end
                  end else begin
                     // Release bounce: the key is still the same press.
                     r_state <= PRESSED;
                  end
               end

               default: r_state <= SCAN;
            endcase
         end
      end
   end

   assign teclasalida = r_col_drive;

   // ------------------------------------------------------------------
   // Key FIFO and sticky overflow
   // ------------------------------------------------------------------
   logic w_fifo_empty;
   logic w_ovf_pulse;
   logic w_unused_fifo_full;
   logic r_overflow;

   teclado_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (KEY_W)
   ) u_fifo (
      .clk              (clk),
      .reset            (reset),
      .i_push           (w_push),
      .i_push_data      (w_push_code),
      .i_pop            (key_pop),
      .o_head_data      (key_code),
      .o_full           (w_unused_fifo_full),
      .o_empty          (w_fifo_empty),
      .o_count          (fifo_count),
      .o_overflow_pulse (w_ovf_pulse)
   );

   assign key_valid = ~w_fifo_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_ovf_pulse) begin
         r_overflow <= 1'b1;
      end else if (clr_overflow) begin
         r_overflow <= 1'b0;
      end
   end

   assign overflow = r_overflow;

endmodule : teclado_scan_ctrl
`default_nettype wire

// File: doc/teclado_scan_ctrl.md
# teclado_scan_ctrl

Matrix-keypad scan controller for the 3-column × 4-row bicycle-rack keypad.
- Drives the column lines one at a time and samples the four row lines.
- Debounces press and release, encodes the key, and queues key codes in a small show-ahead FIFO.
- Sits between the keypad pins and the Wishbone keypad peripheral. The peripheral pops codes through a valid/pop handshake.

## Interface
Parameters:
- SCAN_DIV, default 50000: clock cycles each column is driven (dwell); must be ≥ 4.
- DEBOUNCE_SCANS, default 4: consecutive matching samples needed to accept a press or a release; ≥ 1.
- FIFO_DEPTH, default 4: key FIFO entries; power of two, ≥ 2.
- REPEAT_SCANS, default 64: dwell periods between auto-repeat pushes (used only with the macro).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- entrada1..entrada4  in  1 each  row inputs, active-low (pulled up), asynchronous to clk
- teclasalida  out  3  column drive, one-cold active-low
- key_code  out  4  FIFO head code, 0..11
- key_valid  out  1  FIFO non-empty
- key_pop  in  1  consumer pop strobe
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky flag: a key was dropped
- clr_overflow  in  1  clears overflow

## Operation
- Rows pass through a 2-FF synchronizer, giving row_s[3:0] (bit i = entrada(i+1)).
- Column index col cycles 0→1→2→0. teclasalida has bit col low and the others high (col0 = 3'b110).
- A dwell counter runs 0..SCAN_DIV-1. The sample point is count == SCAN_DIV-1.
- Key code = col*4 + row, where row is the lowest-index low bit of row_s.
- FSM states:
  - SCAN:
    - At a sample point with row_s == 4'hF: advance col.
    - At a sample point with any row low: latch cand_row, set deb_cnt = 1, go to DEBOUNCE. col is held.
  - DEBOUNCE:
    - At each sample point, if the same cand_row is still the lowest low row: deb_cnt++.
    - When deb_cnt reaches DEBOUNCE_SCANS: push the code and go to PRESSED.
    - On a mismatch (bounce): go to SCAN and advance col.
    - With DEBOUNCE_SCANS = 1, the push happens on the SCAN detection sample itself.
  - PRESSED: col is held. At the first sample point with row_s == 4'hF: deb_cnt = 1, go to RELEASE.
  - RELEASE:
    - At each sample point with row_s == 4'hF: deb_cnt++.
    - When deb_cnt reaches DEBOUNCE_SCANS: go to SCAN and advance col.
    - At a sample point with any row low: return to PRESSED without pushing.
- FIFO behaviour:
  - Show-ahead: key_code always shows the head entry.
  - A pop happens when key_valid & key_pop. key_pop while empty is ignored.
  - A push while full is dropped and sets overflow. A push and a pop in the same cycle while full both occur: no drop, count unchanged.
  - clr_overflow clears overflow. If a set and clr_overflow occur in the same cycle, the set wins.
- Only one key is tracked per press. Other keys are ignored until release completes.

## Timing
- Reset values: teclasalida = 3'b110, key_code = 0, key_valid = 0, fifo_count = 0, overflow = 0. FSM = SCAN, col = 0, dwell counter = 0.
- Reset mid-operation empties the FIFO and abandons any press immediately (asynchronous).
- The push occurs in the sample-point cycle. key_valid and fifo_count update on the next edge, so latency is 1 cycle.
- A pop takes effect at the clock edge: key_code and fifo_count show the new head and occupancy on the following cycle.
- Synchronizer delay is 2 cycles. It is absorbed because SCAN_DIV ≥ 4 and sampling happens only at the end of the dwell.
- The dwell counter restarts at 0 after every sample point, in all states.

## Configuration
- TECLADO_AUTOREPEAT_EN defined:
  - In PRESSED, a repeat counter counts sample points with the key still held.
  - Every REPEAT_SCANS held samples it pushes the same code again, then restarts the count.
  - The counter clears on entry to PRESSED.
- TECLADO_AUTOREPEAT_EN undefined: exactly one push per debounced press. REPEAT_SCANS is unused and there is no repeat logic.

## Structure
- Package teclado_pkg contains:
  - NUM_COLS = 3, NUM_ROWS = 4, KEY_W = 4;
  - FSM state enum (SCAN, DEBOUNCE, PRESSED, RELEASE);
  - key-encode function.
- One sub-module: teclado_fifo. It is a parameterised synchronous show-ahead FIFO with push, pop, full, empty, count and an overflow pulse.

## Test plan
Bench parameters: SCAN_DIV = 4, DEBOUNCE_SCANS = 2, FIFO_DEPTH = 4.
- Reset released, no keys pressed → teclasalida cycles 110→101→011→110, changing every 4 cycles; key_valid stays 0.
- entrada3 held low while col = 1 → code 6 pushed on the second sample point. key_valid = 1, key_code = 6 one cycle later. Pop gives fifo_count = 0.
- entrada1 low for one sample only during col = 2 (bounce) → no push; col advances to 0.
- Five distinct presses with no pops → fifo_count = 4, overflow = 1. Pop and clr_overflow pulsed in the same cycle → count 3, overflow 0.
- Key held, released for one sample, then pressed again, all on col = 0 → only one push (RELEASE returns to PRESSED).
- With TECLADO_AUTOREPEAT_EN and REPEAT_SCANS = 3: key 0 held for 10 sample points after acceptance → 4 pushes of code 0.
